// File: rtl/nco_chirp_gen.sv
// Queued sweep-command angle generator for the NCO: linear phase or quadratic chirp.
// Commands sit in a small FIFO; sweeps chain back-to-back and abort flushes everything.
module nco_chirp_gen #(
  parameter int PHASE_W   = 32,
  parameter int LEN_W     = 32,
  parameter int CMD_DEPTH = 4,
  localparam int AW       = $clog2(CMD_DEPTH),
  localparam int LW       = $clog2(CMD_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [PHASE_W-1:0] cfg_start_angle,
  input  logic [PHASE_W-1:0] cfg_delta,
  input  logic [PHASE_W-1:0] cfg_delta_rate,
  input  logic [LEN_W-1:0]   cfg_length,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               abort,
  output logic [PHASE_W-1:0] out_angle,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [LW-1:0]      cmd_level
);

  typedef struct packed {
    logic [PHASE_W-1:0] start;
    logic [PHASE_W-1:0] delta;
    logic [PHASE_W-1:0] rate;
    logic [LEN_W-1:0]   len;
  } cmd_t;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  cmd_t               r_mem [CMD_DEPTH];
  logic [AW-1:0]      r_wp, r_rp;
  logic [LW-1:0]      r_cnt;
  state_t             r_state, w_nstate;
  logic [PHASE_W-1:0] r_angle, r_delta, r_rate;
  logic [LEN_W-1:0]   r_rem;
  logic               r_vld, r_done;

  cmd_t w_head;
  logic w_full, w_empty, w_push, w_pop, w_load, w_xfer, w_last_xfer;

  assign w_head      = r_mem[r_rp];
  assign w_full      = (r_cnt == LW'(CMD_DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign cfg_ready   = !w_full && !abort;
  assign w_push      = cfg_valid && cfg_ready;
  assign w_xfer      = r_vld && out_ready;
  assign w_last_xfer = w_xfer && (r_rem == LEN_W'(1));
  assign w_load      = w_pop && (w_head.len != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= '{cfg_start_angle, cfg_delta, cfg_delta_rate, cfg_length};
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (abort) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) r_state <= S_IDLE;
    else      r_state <= w_nstate;
  end

  // Pop from idle, or on the final beat so the next sweep follows with no bubble.
  always_comb begin
    w_nstate = r_state;
    w_pop    = 1'b0;
    if (abort) begin
      w_nstate = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head.len != '0) w_nstate = S_RUN;
        end
        S_RUN: if (w_last_xfer) begin
          if (!w_empty) begin
            w_pop = 1'b1;
            if (w_head.len == '0) w_nstate = S_IDLE;
          end else begin
            w_nstate = S_IDLE;
          end
        end
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  // A sweep loaded from idle spends one priming cycle in RUN before out_valid rises.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_angle <= '0;
      r_delta <= '0;
      r_rate  <= '0;
      r_rem   <= '0;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last_xfer && !abort;
      if (abort) begin
        r_vld <= 1'b0;
        r_rem <= '0;
      end else if (w_load) begin
        r_angle <= w_head.start;
        r_delta <= w_head.delta;
        r_rate  <= w_head.rate;
        r_rem   <= w_head.len;
        r_vld   <= (r_state == S_RUN);
      end else if (w_xfer) begin
        r_angle <= r_angle + r_delta;
        r_delta <= r_delta + r_rate;
        r_rem   <= r_rem - LEN_W'(1);
        if (w_last_xfer) r_vld <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_vld <= 1'b1;
      end
    end
  end

  assign out_angle = r_angle;
  assign out_valid = r_vld;
  assign out_last  = r_vld && (r_rem == LEN_W'(1));
  assign done      = r_done;
  assign busy      = (r_state == S_RUN) || !w_empty;
  assign cmd_level = r_cnt;

endmodule
